multicycle_control_ext: RTL and testbench
=========================================

Name: multicycle_control_ext

Overview:
- Parametrised next-generation multicycle MIPS control FSM.
- Drives datapath mux selects and write enables from the current opcode and a memory-ready handshake.
- Adds real MIPS opcode encodings, immediate-ALU ops, BNE and JAL, an illegal-opcode exception path, optional memory wait states, and a retired-instruction counter.
- Sits between the instruction register (Op = IR[31:26]) and the multicycle datapath.

Parameters:
MEM_HANDSHAKE, 1, 1: FETCH/MEMRD/MEMWR hold until mem_ready=1; 0: mem_ready ignored, treated as 1.
EN_EXT, 1, 1: ADDI/ANDI/ORI/BNE/JAL legal; 0: those opcodes take the exception path.
CNT_W, 32, width of instr_count.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
Op  input  6  opcode; stable from DECODE until the next FETCH
mem_ready  input  1  memory access completes this cycle
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
ALUOp  output  2  00 add, 01 sub, 10 funct field, 11 opcode-immediate op
ExtOp  output  1  1 sign-extend, 0 zero-extend immediate
MemRead, MemWrite, IorD, IRWrite  output  1 each  memory/IR control
PCWrite, PCWriteCond, PCWriteCondNe  output  1 each  unconditional / branch-if-zero / branch-if-nonzero
PCSource  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
RegDst  output  2  00 rt, 01 rd, 10 $31
MemtoReg  output  2  00 ALUOut, 01 MDR, 10 PC
RegWrite  output  1  register file write enable
Exception  output  1  one-cycle pulse on illegal opcode
state_out  output  4  current state encoding
instr_count  output  CNT_W  retired instruction count

Behaviour:
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, JAL=000011, ADDI=001000, ANDI=001100, ORI=001101.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, JALS 12, EXC 13. Codes 14–15 go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE when ready, where ready = mem_ready or !MEM_HANDSHAKE; otherwise hold.
  - DECODE→MEMADR (LW/SW), REXEC (R), BRANCH (BEQ/BNE), JUMP (J), IEXEC (ADDI/ANDI/ORI), JALS (JAL), EXC (any other opcode, or an EN_EXT opcode when EN_EXT=0).
  - MEMADR→MEMRD (LW) / MEMWR (SW).
  - MEMRD→MEMWB when ready.
  - MEMWR→FETCH when ready.
  - REXEC→RWB, IEXEC→IWB.
  - MEMWB, RWB, IWB, BRANCH, JUMP, JALS, EXC → FETCH.
- Outputs are a Moore decode of state, except where noted. Every signal not listed for a state is 0.
  - FETCH: MemRead=1, ALUSrcB=01. PCWrite=IRWrite=ready (only on the completing cycle).
  - DECODE: ALUSrcB=11, ExtOp=1.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: MemtoReg=01, RegWrite=1.
  - MEMWR: MemWrite=ready, IorD=1.
  - REXEC: ALUSrcA=1, ALUOp=10.
  - RWB: RegDst=01, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01. PCWriteCond=(Op==BEQ), PCWriteCondNe=(Op==BNE).
  - JUMP: PCWrite=1, PCSource=10.
  - IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11, ExtOp=(Op==ADDI).
  - IWB: RegWrite=1.
  - JALS: PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1.
  - EXC: PCWrite=1, PCSource=11, Exception=1.
- Zero-wait latency in cycles: LW 5, SW 4, R 4, ADDI/ANDI/ORI 4, BEQ/BNE 3, J 3, JAL 3, illegal 3. Each wait cycle adds 1 at a handshake state.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP or JALS.
  - It does not increment from EXC or from states 14–15.
  - It wraps modulo 2^CNT_W.
- Reset: while reset_n=0 at a rising edge, state←FETCH and instr_count←0. All control outputs are forced to 0 while reset_n=0. Reset mid-instruction (including mid-wait) aborts it without counting.
- mem_ready asserted outside handshake states is ignored.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles during MEMRD → state_out=0, all controls 0, instr_count=0. After release, FETCH shows MemRead=1, ALUSrcB=01.
- LW, MEM_HANDSHAKE=0, Op=100011 → states 0,1,2,3,4 then 0. RegWrite=1 with MemtoReg=01 in state 4. instr_count 0→1.
- SW with mem_ready low for 3 cycles in MEMWR → state 5 held 4 cycles. MemWrite=1 only on the mem_ready cycle. Count increments once.
- BNE then BEQ → in state 8, PCWriteCondNe=1/PCWriteCond=0, then the reverse. ALUOp=01 both times.
- JAL → state 12 drives PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1. Returns to 0 after 3 cycles total.
- Op=111111, and Op=001000 with EN_EXT=0 → EXC: Exception=1 for exactly 1 cycle, PCSource=11, count unchanged. With CNT_W=4, 16 R-type instructions wrap instr_count to 0.

Source files
------------

// File: rtl/multicycle_control_ext.sv
// multicycle_control_ext: multicycle MIPS control FSM with extended opcodes, exception path, memory wait states and retire counter
// ports: clock, reset_n (sync active-low); Op opcode (IR[31:26]); mem_ready handshake;
//        ALUSrcA/ALUSrcB/ALUOp/ExtOp, MemRead/MemWrite/IorD/IRWrite, PCWrite/PCWriteCond/PCWriteCondNe/PCSource,
//        RegDst/MemtoReg/RegWrite datapath controls; Exception pulse; state_out; instr_count retired instructions
module multicycle_control_ext #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EN_EXT = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             ExtOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCWriteCondNe,
  output logic [1:0]       PCSource,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             Exception,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB,
    BRANCH, JUMP, IEXEC, IWB, JALS, EXC
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011,
    OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ready, retire;
  always_comb begin
    ready = mem_ready | !MEM_HANDSHAKE;
    {ALUSrcA, ALUSrcB, ALUOp, ExtOp, MemRead, MemWrite, IorD, IRWrite, PCWrite,
     PCWriteCond, PCWriteCondNe, PCSource, RegDst, MemtoReg, RegWrite, Exception} = '0;
    state_d = FETCH;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = ready;
        IRWrite = ready;
        state_d = ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ExtOp = 1'b1;
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R: state_d = REXEC;
          OP_BEQ: state_d = BRANCH;
          OP_BNE: state_d = EN_EXT ? BRANCH : EXC;
          OP_J: state_d = JUMP;
          OP_JAL: state_d = EN_EXT ? JALS : EXC;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = EN_EXT ? IEXEC : EXC;
          default: state_d = EXC;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp = 1'b1;
        state_d = (Op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        state_d = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        MemWrite = ready;
        IorD = 1'b1;
        state_d = ready ? FETCH : MEMWR;
      end
      REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        state_d = RWB;
      end
      RWB: begin
        RegDst = 2'b01;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCSource = 2'b01;
        PCWriteCond = Op == OP_BEQ;
        PCWriteCondNe = Op == OP_BNE;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp = 2'b11;
        ExtOp = Op == OP_ADDI;
        state_d = IWB;
      end
      IWB: RegWrite = 1'b1;
      JALS: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
        RegDst = 2'b10;
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
      end
      EXC: begin
        PCWrite = 1'b1;
        PCSource = 2'b11;
        Exception = 1'b1;
      end
      default: ;
    endcase
    // EXC and the unused codes return to FETCH without retiring anything
    retire = state_d == FETCH && state_q inside {MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP, JALS};
    cnt_d = cnt_q + CNT_W'(retire);
    if (!reset_n)
      {ALUSrcA, ALUSrcB, ALUOp, ExtOp, MemRead, MemWrite, IorD, IRWrite, PCWrite,
       PCWriteCond, PCWriteCondNe, PCSource, RegDst, MemtoReg, RegWrite, Exception} = '0;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign state_out = state_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control_ext.sv
// tb_multicycle_control_ext: directed checks of the multicycle control FSM in three parameter configurations
module tb_multicycle_control_ext;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
    BNE = 6'b000101, JAL = 6'b000011, ADDI = 6'b001000, ORI = 6'b001101;
  logic clock, mr, ra, rb, rc;
  logic [5:0] op_a, op_b, op_c;
  int total = 0, bad = 0;
  logic a_ALUSrcA, a_ExtOp, a_MemRead, a_MemWrite, a_IorD, a_IRWrite, a_PCWrite, a_PCWriteCond, a_PCWriteCondNe, a_RegWrite, a_Exception;
  logic [1:0] a_ALUSrcB, a_ALUOp, a_PCSource, a_RegDst, a_MemtoReg;
  logic [3:0] a_state;
  logic [31:0] a_cnt;
  logic b_ALUSrcA, b_ExtOp, b_MemRead, b_MemWrite, b_IorD, b_IRWrite, b_PCWrite, b_PCWriteCond, b_PCWriteCondNe, b_RegWrite, b_Exception;
  logic [1:0] b_ALUSrcB, b_ALUOp, b_PCSource, b_RegDst, b_MemtoReg;
  logic [3:0] b_state;
  logic [31:0] b_cnt;
  logic c_ALUSrcA, c_ExtOp, c_MemRead, c_MemWrite, c_IorD, c_IRWrite, c_PCWrite, c_PCWriteCond, c_PCWriteCondNe, c_RegWrite, c_Exception;
  logic [1:0] c_ALUSrcB, c_ALUOp, c_PCSource, c_RegDst, c_MemtoReg;
  logic [3:0] c_state;
  logic [3:0] c_cnt;
  logic [20:0] a_ctl;
  assign a_ctl = {a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_ExtOp, a_MemRead, a_MemWrite, a_IorD, a_IRWrite, a_PCWrite,
                  a_PCWriteCond, a_PCWriteCondNe, a_PCSource, a_RegDst, a_MemtoReg, a_RegWrite, a_Exception};
  multicycle_control_ext dut_a (
    .clock(clock), .reset_n(ra), .Op(op_a), .mem_ready(mr),
    .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .ExtOp(a_ExtOp),
    .MemRead(a_MemRead), .MemWrite(a_MemWrite), .IorD(a_IorD), .IRWrite(a_IRWrite),
    .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .PCWriteCondNe(a_PCWriteCondNe), .PCSource(a_PCSource),
    .RegDst(a_RegDst), .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite), .Exception(a_Exception),
    .state_out(a_state), .instr_count(a_cnt)
  );
  multicycle_control_ext #(.MEM_HANDSHAKE(1'b0)) dut_b (
    .clock(clock), .reset_n(rb), .Op(op_b), .mem_ready(mr),
    .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .ExtOp(b_ExtOp),
    .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IorD(b_IorD), .IRWrite(b_IRWrite),
    .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .PCWriteCondNe(b_PCWriteCondNe), .PCSource(b_PCSource),
    .RegDst(b_RegDst), .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .Exception(b_Exception),
    .state_out(b_state), .instr_count(b_cnt)
  );
  multicycle_control_ext #(.EN_EXT(1'b0), .CNT_W(4)) dut_c (
    .clock(clock), .reset_n(rc), .Op(op_c), .mem_ready(mr),
    .ALUSrcA(c_ALUSrcA), .ALUSrcB(c_ALUSrcB), .ALUOp(c_ALUOp), .ExtOp(c_ExtOp),
    .MemRead(c_MemRead), .MemWrite(c_MemWrite), .IorD(c_IorD), .IRWrite(c_IRWrite),
    .PCWrite(c_PCWrite), .PCWriteCond(c_PCWriteCond), .PCWriteCondNe(c_PCWriteCondNe), .PCSource(c_PCSource),
    .RegDst(c_RegDst), .MemtoReg(c_MemtoReg), .RegWrite(c_RegWrite), .Exception(c_Exception),
    .state_out(c_state), .instr_count(c_cnt)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    ra = 0; rb = 0; rc = 0; mr = 0; op_a = LW; op_b = LW; op_c = R;
    tick; tick;
    ra = 1; #1;
    chk("a_rst_state", a_state, 0);
    chk("a_rst_cnt", a_cnt, 0);
    chk("a_fetch_memread_srcb", {a_MemRead, a_ALUSrcB}, 3'b101);
    chk("a_fetch_wait_pcw_irw", {a_PCWrite, a_IRWrite}, 0);
    mr = 1; #1;
    chk("a_fetch_ready_pcw_irw", {a_PCWrite, a_IRWrite}, 2'b11);
    tick;
    chk("a_decode_state", a_state, 1);
    chk("a_decode_srcb_ext", {a_ALUSrcB, a_ExtOp}, 3'b111);
    tick;
    chk("a_memadr_state", a_state, 2);
    chk("a_memadr_ctl", {a_ALUSrcA, a_ALUSrcB, a_ExtOp}, 4'b1101);
    tick;
    mr = 0; #1;
    chk("a_memrd_state", a_state, 3);
    tick;
    chk("a_memrd_hold_state", a_state, 3);
    chk("a_memrd_ctl", {a_MemRead, a_IorD}, 2'b11);
    ra = 0; #1;
    chk("a_rst_ctl_gated", a_ctl, 0);
    tick; tick;
    chk("a_rst2_state", a_state, 0);
    chk("a_rst2_ctl", a_ctl, 0);
    chk("a_rst2_cnt", a_cnt, 0);
    ra = 1; #1;
    chk("a_rel_fetch", {a_MemRead, a_ALUSrcB}, 3'b101);
    op_a = SW; mr = 1;
    tick; tick; tick;
    mr = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("a_sw_wait_state", a_state, 5);
      chk("a_sw_wait_memwrite", {a_MemWrite, a_IorD}, 2'b01);
      tick;
    end
    mr = 1; #1;
    chk("a_sw_ready_state", a_state, 5);
    chk("a_sw_ready_memwrite", {a_MemWrite, a_IorD}, 2'b11);
    chk("a_sw_cnt_before", a_cnt, 0);
    tick;
    chk("a_sw_done_state", a_state, 0);
    chk("a_sw_cnt", a_cnt, 1);
    op_a = BNE; tick; tick;
    chk("a_bne_state", a_state, 8);
    chk("a_bne_cond", {a_PCWriteCond, a_PCWriteCondNe}, 2'b01);
    chk("a_bne_aluop_pcsrc", {a_ALUOp, a_PCSource, a_ALUSrcA}, 5'b01011);
    tick;
    chk("a_bne_cnt", a_cnt, 2);
    op_a = BEQ; tick; tick;
    chk("a_beq_cond", {a_PCWriteCond, a_PCWriteCondNe}, 2'b10);
    chk("a_beq_aluop", a_ALUOp, 2'b01);
    tick;
    chk("a_beq_cnt", a_cnt, 3);
    op_a = JAL; tick; tick;
    chk("a_jal_state", a_state, 12);
    chk("a_jal_ctl", {a_PCWrite, a_PCSource, a_RegDst, a_MemtoReg, a_RegWrite}, 8'b1_10_10_10_1);
    tick;
    chk("a_jal_ret_state", a_state, 0);
    chk("a_jal_cnt", a_cnt, 4);
    op_a = 6'b111111; tick; tick;
    chk("a_ill_state", a_state, 13);
    chk("a_ill_ctl", {a_PCWrite, a_PCSource, a_Exception}, 4'b1111);
    tick;
    chk("a_ill_pulse_end", {a_state, a_Exception}, 0);
    chk("a_ill_cnt", a_cnt, 4);
    op_a = ADDI; tick; tick;
    chk("a_addi_exec", {a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_ExtOp}, 6'b1_10_11_1);
    tick;
    chk("a_addi_wb", {a_state, a_RegWrite, a_RegDst}, 7'b1011_1_00);
    tick;
    chk("a_addi_cnt", a_cnt, 5);
    op_a = ORI; tick; tick;
    chk("a_ori_exec", {a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_ExtOp}, 6'b1_10_11_0);
    tick; tick;
    chk("a_ori_cnt", a_cnt, 6);
    mr = 0; rb = 1; #1;
    chk("b_fetch_nohs", {b_state, b_PCWrite, b_IRWrite}, 6'b0000_11);
    tick;
    chk("b_lw_s1", b_state, 1);
    tick;
    chk("b_lw_s2", b_state, 2);
    tick;
    chk("b_lw_s3", {b_state, b_MemRead, b_IorD}, 6'b0011_11);
    tick;
    chk("b_lw_s4", {b_state, b_RegWrite, b_MemtoReg}, 7'b0100_1_01);
    tick;
    chk("b_lw_done", b_state, 0);
    chk("b_lw_cnt", b_cnt, 1);
    mr = 1; op_c = ADDI; rc = 1; #1;
    chk("c_rst_state", c_state, 0);
    tick; tick;
    chk("c_addi_exc", {c_state, c_Exception, c_PCSource}, 7'b1101_1_11);
    tick;
    chk("c_addi_after", {c_state, c_Exception}, 0);
    chk("c_addi_cnt", c_cnt, 0);
    op_c = JAL; tick; tick;
    chk("c_jal_exc", c_state, 13);
    tick;
    op_c = R;
    for (int i = 0; i < 16; i++) begin
      tick; tick;
      if (i == 0) chk("c_r_exec", {c_state, c_ALUSrcA, c_ALUOp}, 7'b0110_1_10);
      tick;
      if (i == 0) chk("c_r_wb", {c_state, c_RegDst, c_RegWrite}, 7'b0111_01_1);
      tick;
      if (i == 14) chk("c_cnt_15", c_cnt, 15);
    end
    chk("c_cnt_wrap", c_cnt, 0);
    chk("c_wrap_state", c_state, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
